rvi_insn_encoder: RTL and testbench

RVI_INSN_ENCODER -- requirements
Module: rvi_insn_encoder

---
 rtl/rvi_insn_encoder.sv | 227 ++++++++++++++++++++++
 tb/tb_rvi_insn_encoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvi_insn_encoder.sv
`default_nettype none
// ============================================================================
// rvi_insn_encoder : two-stage RV32I instruction encoder with legality checks
//                    and saturating good/error beat counters.   Rev 1.0
// ============================================================================
module rvi_insn_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [9:0]       in_funct,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_insn,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;
   localparam logic [6:0] c_opc_branch = 7'b1100011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_f7_zero    = 7'b0000000;
   localparam logic [6:0] c_f7_alt     = 7'b0100000;

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_SH = 3'd2,
      FMT_S  = 3'd3,
      FMT_B  = 3'd4,
      FMT_U  = 3'd5,
      FMT_J  = 3'd6
   } fmt_e;

   logic [6:0]  w_f7;
   logic [2:0]  w_f3;
   logic        w_imm_i_ok;
   logic        w_imm_sh_ok;
   logic        w_imm_b_ok;
   logic        w_imm_j_ok;
   logic        w_in_fire;
   logic        w_out_fire;
   logic        s2_advance;

   fmt_e        s1_fmt_d;
   logic        s1_err_d;
   logic [31:0] s2_insn_d;

   logic        s1_valid_q;
   fmt_e        s1_fmt_q;
   logic        s1_err_q;
   logic [6:0]  s1_opcode_q;
   logic [9:0]  s1_funct_q;
   logic [4:0]  s1_rd_q;
   logic [4:0]  s1_rs1_q;
   logic [4:0]  s1_rs2_q;
   logic [31:0] s1_imm_q;

   logic             s2_valid_q;
   logic [31:0]      s2_insn_q;
   logic             s2_err_q;
   logic [CNT_W-1:0] enc_count_q;
   logic [CNT_W-1:0] err_count_q;

   assign w_f7 = in_funct[9:3];
   assign w_f3 = in_funct[2:0];

   // Range checks: upper immediate bits must be a pure sign extension.
   assign w_imm_i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign w_imm_sh_ok = ~(|in_imm[31:5]);
   assign w_imm_b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
   assign w_imm_j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

   always_comb begin
      s1_fmt_d = FMT_R;
      s1_err_d = 1'b0;
      case (in_opcode)
         c_opc_op: begin
            s1_fmt_d = FMT_R;
            s1_err_d = !((w_f7 == c_f7_zero) ||
                         ((w_f7 == c_f7_alt) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
         end
         c_opc_op_imm: begin
            if (w_f3 == 3'b001) begin
               s1_fmt_d = FMT_SH;
               s1_err_d = !((w_f7 == c_f7_zero) && w_imm_sh_ok);
            end else if (w_f3 == 3'b101) begin
               s1_fmt_d = FMT_SH;
               s1_err_d = !(((w_f7 == c_f7_zero) || (w_f7 == c_f7_alt)) && w_imm_sh_ok);
            end else begin
               s1_fmt_d = FMT_I;
               s1_err_d = !((w_f7 == c_f7_zero) && w_imm_i_ok);
            end
         end
         c_opc_load: begin
            s1_fmt_d = FMT_I;
            s1_err_d = !((w_f7 == c_f7_zero) && (w_f3 != 3'b011) && (w_f3 != 3'b110) &&
                         (w_f3 != 3'b111) && w_imm_i_ok);
         end
         c_opc_jalr: begin
            s1_fmt_d = FMT_I;
            s1_err_d = !((in_funct == 10'd0) && w_imm_i_ok);
         end
         c_opc_store: begin
            s1_fmt_d = FMT_S;
            s1_err_d = !((w_f7 == c_f7_zero) && (w_f3 <= 3'b010) && w_imm_i_ok);
         end
         c_opc_branch: begin
            s1_fmt_d = FMT_B;
            s1_err_d = !((w_f7 == c_f7_zero) && (w_f3 != 3'b010) && (w_f3 != 3'b011) &&
                         w_imm_b_ok);
         end
         c_opc_lui, c_opc_auipc: begin
            s1_fmt_d = FMT_U;
         end
         c_opc_jal: begin
            s1_fmt_d = FMT_J;
            s1_err_d = !w_imm_j_ok;
         end
         default: begin
            s1_err_d = 1'b1;
         end
      endcase
   end

   always_comb begin
      s2_insn_d = 32'h0000_0000;
      case (s1_fmt_q)
         FMT_R:  s2_insn_d = {s1_funct_q[9:3], s1_rs2_q, s1_rs1_q, s1_funct_q[2:0],
                              s1_rd_q, s1_opcode_q};
         FMT_I:  s2_insn_d = {s1_imm_q[11:0], s1_rs1_q, s1_funct_q[2:0], s1_rd_q, s1_opcode_q};
         FMT_SH: s2_insn_d = {s1_funct_q[9:3], s1_imm_q[4:0], s1_rs1_q, s1_funct_q[2:0],
                              s1_rd_q, s1_opcode_q};
         FMT_S:  s2_insn_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct_q[2:0],
                              s1_imm_q[4:0], s1_opcode_q};
         FMT_B:  s2_insn_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                              s1_funct_q[2:0], s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
         FMT_U:  s2_insn_d = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
         FMT_J:  s2_insn_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                              s1_rd_q, s1_opcode_q};
         default: s2_insn_d = 32'h0000_0000;
      endcase
      if (s1_err_q) begin
         s2_insn_d = 32'h0000_0000;
      end
   end

   assign s2_advance = !s2_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || s2_advance;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = s2_valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_fmt_q    <= FMT_R;
         s1_err_q    <= 1'b0;
         s1_opcode_q <= 7'd0;
         s1_funct_q  <= 10'd0;
         s1_rd_q     <= 5'd0;
         s1_rs1_q    <= 5'd0;
         s1_rs2_q    <= 5'd0;
         s1_imm_q    <= 32'd0;
         s2_valid_q  <= 1'b0;
         s2_insn_q   <= 32'd0;
         s2_err_q    <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
         if (w_in_fire) begin
            s1_fmt_q    <= s1_fmt_d;
            s1_err_q    <= s1_err_d;
            s1_opcode_q <= in_opcode;
            s1_funct_q  <= in_funct;
            s1_rd_q     <= in_rd;
            s1_rs1_q    <= in_rs1;
            s1_rs2_q    <= in_rs2;
            s1_imm_q    <= in_imm;
         end
         // Output word only changes when S2 may advance, keeping it stable under stall.
         if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_insn_q <= s2_insn_d;
               s2_err_q  <= s1_err_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enc_count_q <= '0;
         err_count_q <= '0;
      end else if (w_out_fire) begin
         if (!s2_err_q && (enc_count_q != '1)) begin
            enc_count_q <= enc_count_q + CNT_W'(1);
         end
         if (s2_err_q && (err_count_q != '1)) begin
            err_count_q <= err_count_q + CNT_W'(1);
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_insn  = s2_insn_q;
   assign out_err   = s2_err_q;
   assign enc_count = enc_count_q;
   assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rvi_insn_encoder.sv
`default_nettype none
// tb_rvi_insn_encoder: scoreboard bench with directed RV32I vectors and a
// randomized stream checked against an arithmetic encoding model.
module tb_rvi_insn_encoder;
   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [6:0]       in_opcode = '0;
   logic [9:0]       in_funct = '0;
   logic [4:0]       in_rd = '0;
   logic [4:0]       in_rs1 = '0;
   logic [4:0]       in_rs2 = '0;
   logic [31:0]      in_imm = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_insn;
   logic             out_err;
   logic [CNT_W-1:0] enc_count;
   logic [CNT_W-1:0] err_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          rdy_mode = 0;
   int          exp_enc = 0;
   int          exp_err = 0;
   logic [32:0] sb[$];

   rvi_insn_encoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct(in_funct),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_insn(out_insn), .out_err(out_err),
      .enc_count(enc_count), .err_count(err_count)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference encoder: legality by numeric range, fields placed by shifting.
   function automatic logic [32:0] model(input logic [6:0] op, input logic [9:0] f,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
      int unsigned f7, f3, o, d, r1, r2, u, w, base;
      longint      s;
      bit          ok;
      f7 = 32'(f) / 8;  f3 = 32'(f) % 8;
      o = 32'(op); d = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2); u = imm;
      s = longint'($signed(imm));
      base = (r1 << 15) | (f3 << 12) | (d << 7) | o;
      ok = 1'b0; w = 0;
      case (op)
         OPC_OP: begin
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            w  = (f7 << 25) | (r2 << 20) | base;
         end
         OPC_OPIMM: begin
            if (f3 == 1 || f3 == 5) begin
               ok = (f7 == 0 || (f3 == 5 && f7 == 32)) && (u < 32);
               w  = (f7 << 25) | ((u % 32) << 20) | base;
            end else begin
               ok = (f7 == 0) && s >= -2048 && s <= 2047;
               w  = ((u % 4096) << 20) | base;
            end
         end
         OPC_LOAD: begin
            ok = (f7 == 0) && (f3 inside {0, 1, 2, 4, 5}) && s >= -2048 && s <= 2047;
            w  = ((u % 4096) << 20) | base;
         end
         OPC_JALR: begin
            ok = (f == 0) && s >= -2048 && s <= 2047;
            w  = ((u % 4096) << 20) | base;
         end
         OPC_STORE: begin
            ok = (f7 == 0) && (f3 <= 2) && s >= -2048 && s <= 2047;
            w  = (((u >> 5) % 128) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
                 ((u % 32) << 7) | o;
         end
         OPC_BRANCH: begin
            ok = (f7 == 0) && f3 != 2 && f3 != 3 && s >= -4096 && s <= 4095 && (s % 2 == 0);
            w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15) |
                 (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | o;
         end
         OPC_LUI, OPC_AUIPC: begin
            ok = 1'b1;
            w  = (u & 32'hFFFF_F000) | (d << 7) | o;
         end
         OPC_JAL: begin
            ok = s >= -1048576 && s <= 1048575 && (s % 2 == 0);
            w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
                 (((u >> 12) & 255) << 12) | (d << 7) | o;
         end
         default: ok = 1'b0;
      endcase
      return ok ? {1'b0, w} : {1'b1, 32'h0};
   endfunction

   // out_ready: 0 = held high, 1 = random, 2 = held low
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            exp_enc = 0;
            exp_err = 0;
         end else if (out_valid && out_ready) begin
            check("enc_count_run", 64'(enc_count), 64'(exp_enc));
            check("err_count_run", 64'(err_count), 64'(exp_err));
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: got insn %0h err %0b with nothing expected",
                        out_insn, out_err);
            end else begin
               e = sb.pop_front();
               check("out_insn", 64'(out_insn), 64'(e[31:0]));
               check("out_err", 64'(out_err), 64'(e[32]));
               if (e[32]) begin
                  if (exp_err < MAXC) exp_err++;
               end else begin
                  if (exp_enc < MAXC) exp_enc++;
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [6:0] op, input logic [9:0] f, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [32:0] exp);
      int   guard = 0;
      logic acc = 1'b0;
      in_valid = 1'b1; in_opcode = op; in_funct = f;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      while (!acc && guard < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid = 1'b0;
      if (acc) begin
         sb.push_back(exp);
      end else begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
      end
   endtask

   task automatic send_m(input logic [6:0] op, input logic [9:0] f, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      send(op, f, rd, rs1, rs2, imm, model(op, f, rd, rs1, rs2, imm));
   endtask

   task automatic drain();
      int g = 0;
      while ((sb.size() != 0 || out_valid) && g < 200) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic send_rand();
      logic [6:0]  ops[11];
      logic [6:0]  op;
      logic [9:0]  f;
      logic [31:0] imm;
      int          k;
      ops = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR,
              OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, 7'd0};
      k  = $urandom_range(0, 10);
      op = (k == 10) ? 7'($urandom) : ops[k];
      case ($urandom_range(0, 3))
         0:       f = {7'($urandom), 3'($urandom)};
         1:       f = {7'b0100000, 3'($urandom)};
         default: f = {7'b0000000, 3'($urandom)};
      endcase
      if (op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL) f = 10'd0;
      if (op == OPC_JALR && $urandom_range(0, 3) != 0) f = 10'd0;
      case ($urandom_range(0, 4))
         0:       imm = 32'($urandom_range(0, 128)) - 32'd64;
         1:       imm = 32'($urandom_range(0, 10000)) - 32'd5000;
         2:       imm = $urandom;
         3:       imm = 32'($urandom_range(0, 40));
         default: imm = 32'($urandom_range(0, 32'h0030_0000)) - 32'h0018_0000;
      endcase
      send_m(op, f, 5'($urandom), 5'($urandom), 5'($urandom), imm);
   endtask

   initial begin
      int stale;
      // Reset state
      idle(3);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      check("rst_out_insn", 64'(out_insn), 64'd0);
      check("rst_enc_count", 64'(enc_count), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // ADDI with two-cycle latency
      send(OPC_OPIMM, 10'd0, 5'd1, 5'd0, 5'd0, 32'd5, {1'b0, 32'h0050_0093});
      @(negedge clk);
      check("latency_cycle1_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("latency_cycle2_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;

      send(OPC_BRANCH, 10'd0, 5'd0, 5'd1, 5'd2, -32'sd4, {1'b0, 32'hFE20_8EE3});
      send(OPC_BRANCH, 10'd0, 5'd0, 5'd1, 5'd2, 32'd3, {1'b1, 32'h0});
      drain();
      @(negedge clk);
      check("beq_err_count", 64'(err_count), 64'd1);
      check("beq_enc_count", 64'(enc_count), 64'd2);
      @(posedge clk);
      #1;

      send(OPC_JAL, 10'd0, 5'd1, 5'd0, 5'd0, 32'd2048, {1'b0, 32'h0010_00EF});
      send(OPC_OPIMM, 10'b0100000_101, 5'd3, 5'd3, 5'd0, 32'd31, {1'b0, 32'h41F1_D193});
      send(OPC_SYSTEM, 10'd0, 5'd1, 5'd2, 5'd3, 32'd0, {1'b1, 32'h0});
      send(OPC_LOAD, 10'b0000000_010, 5'd4, 5'd5, 5'd0, 32'd2048, {1'b1, 32'h0});
      drain();
      @(negedge clk);
      check("dir_err_count", 64'(err_count), 64'd3);
      check("dir_enc_count", 64'(enc_count), 64'd4);
      @(posedge clk);
      #1;

      // Back-to-back stream with a 5-cycle downstream stall
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send_m(OPC_OPIMM, 10'd0, 5'(i + 1), 5'(i), 5'd0, 32'(i * 3));
            end
         end
         begin
            repeat (3) @(posedge clk);
            rdy_mode = 2;
            @(negedge clk);
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            repeat (4) @(posedge clk);
            rdy_mode = 0;
         end
      join
      drain();
      @(negedge clk);
      check("stream_enc_count", 64'(enc_count), 64'd10);
      @(posedge clk);
      #1;

      // Reset with two beats in flight
      send_m(OPC_OP, 10'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      send_m(OPC_LUI, 10'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5000);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("inflight_rst_valid", 64'(out_valid), 64'd0);
      check("inflight_rst_enc", 64'(enc_count), 64'd0);
      check("inflight_rst_err", 64'(err_count), 64'd0);
      rst = 1'b0;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("no_stale_word", 64'(stale), 64'd0);
      @(posedge clk);
      #1;

      // Randomized traffic with random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         idle($urandom_range(0, 1));
         send_rand();
      end
      rdy_mode = 0;
      drain();
      @(negedge clk);
      check("final_enc_count", 64'(enc_count), 64'(exp_enc));
      check("final_err_count", 64'(err_count), 64'(exp_err));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
